// File: rtl/reg_bank8_xfer_pkg.sv
// Shared constants, opcode and FSM encodings for the 8-register bank.
package reg_bank8_xfer_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_REG = 8;
  localparam int unsigned ADDR_W  = 3;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_SWAP = 2'b01,
    OP_CLR  = 2'b10,
    OP_INC  = 2'b11
  } xf_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_DONE = 3'd4
  } xf_state_e;

  // One-hot select for a 3-bit register index (addr 0 -> bit 0).
  function automatic logic [NUM_REG-1:0] onehot8(input logic [ADDR_W-1:0] a);
    onehot8    = '0;
    onehot8[a] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_bank8_xfer_if.sv
// Bus bundle for the register bank: write port, read port, transfer handshake.
interface reg_bank8_xfer_if
  import reg_bank8_xfer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [0:WIDTH-1]           wr_data;
  logic [ADDR_W-1:0]          rd_addr;
  logic [0:WIDTH-1]           rd_data;
  logic                       xf_start;
  logic [1:0]                 xf_op;
  logic [ADDR_W-1:0]          xf_src;
  logic [ADDR_W-1:0]          xf_dst;
  logic                       xf_busy;
  logic                       xf_done;
  logic [0:NUM_REG*WIDTH-1]   regs_flat;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, xf_start, xf_op, xf_src, xf_dst,
    input  rd_data, xf_busy, xf_done, regs_flat
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, xf_start, xf_op, xf_src, xf_dst,
    output rd_data, xf_busy, xf_done, regs_flat
  );

endinterface

// File: rtl/reg_bank8_xfer_reg8_en.sv
// Single WIDTH-bit register with synchronous active-low reset and load enable.
module reg8_en
  import reg_bank8_xfer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  // Load d when enabled; reset clears.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_bank8_xfer.sv
// Eight general registers with external write/read ports and a small
// register-to-register transfer engine (copy, swap, clear, increment).
module reg_bank8_xfer
  import reg_bank8_xfer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned NREG  = NUM_REG
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_bank8_xfer_if.slave  bus
);

  logic [0:WIDTH-1]       regs  [NREG];
  logic [0:WIDTH-1]       reg_d [NREG];
  logic [NREG-1:0]        reg_en;
  logic [NREG-1:0]        ext_we;
  logic [NREG-1:0]        eng_we;
  logic [0:WIDTH-1]       eng_data;
  logic [0:NREG*WIDTH-1]  flat;

  xf_state_e              state;
  xf_op_e                 op_q;
  logic [ADDR_W-1:0]      src_q;
  logic [ADDR_W-1:0]      dst_q;
  logic [0:WIDTH-1]       t_q;
  logic [0:WIDTH-1]       res_q;
  logic                   busy_q;
  logic                   done_q;

  genvar g;
  for (g = 0; g < NREG; g++) begin : g_reg
    reg8_en #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (reg_en[g]),
      .d     (reg_d[g]),
      .q     (regs[g])
    );
  end

  // Engine write select: WR1 targets dst (or src for swap), WR2 targets dst.
  always_comb begin
    eng_we   = '0;
    eng_data = '0;
    if (state == ST_WR1) begin
      if (op_q == OP_SWAP) begin
        eng_we[src_q] = 1'b1;
        eng_data      = regs[dst_q];
      end else begin
        eng_we[dst_q] = 1'b1;
        eng_data      = res_q;
      end
    end else if (state == ST_WR2) begin
      eng_we[dst_q] = 1'b1;
      eng_data      = t_q;
    end
  end

  // Per-register enable and data; an engine write to a register beats the external one.
  always_comb begin
    ext_we = bus.wr_en ? onehot8(bus.wr_addr) : '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      reg_en[i] = eng_we[i] | ext_we[i];
      reg_d[i]  = eng_we[i] ? eng_data : bus.wr_data;
    end
  end

  // Flatten register state for the downstream read mux, R0 in the top bits.
  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      flat[i*WIDTH +: WIDTH] = regs[i];
    end
  end

  assign bus.regs_flat = flat;
  assign bus.rd_data   = regs[bus.rd_addr];
  assign bus.xf_busy   = busy_q;
  assign bus.xf_done   = done_q;

  // Transfer FSM with registered busy/done; operands latched on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_COPY;
      src_q  <= '0;
      dst_q  <= '0;
      t_q    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.xf_start) begin
            op_q   <= xf_op_e'(bus.xf_op);
            src_q  <= bus.xf_src;
            dst_q  <= bus.xf_dst;
            t_q    <= regs[bus.xf_src];
            busy_q <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          case (op_q)
            OP_CLR:  res_q <= '0;
            OP_INC:  res_q <= t_q + WIDTH'(1);
            default: res_q <= t_q;
          endcase
          state <= ST_WR1;
        end
        ST_WR1: begin
          if (op_q == OP_SWAP) begin
            state <= ST_WR2;
          end else begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_WR2: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank8_xfer.sv
// Directed self-checking bench for reg_bank8_xfer with a register scoreboard.
module tb_reg_bank8_xfer;
  import reg_bank8_xfer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank8_xfer_if bus ();

  reg_bank8_xfer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [8];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] reg_of(input int i);
    logic [63:0] f;
    f = bus.regs_flat;
    return f[63-8*i -: 8];
  endfunction

  task automatic push_model(input string tag);
    for (int i = 0; i < 8; i++) sb.push_back('{tag, i, m[i]});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_R%0d", e.tag, e.idx), {56'd0, reg_of(e.idx)}, {56'd0, e.val});
    end
  endtask

  task automatic wr(input int a, input logic [7:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
    m[a] = v;
  endtask

  // Start an op in cycle 0 and observe cycles 1..8.
  // kind: 0 none, 1 external write in cycle ic, 2 reset in cycle ic.
  task automatic run_op(input logic [1:0] op, input int s, input int d, input bit hold,
                        input int ic, input int kind, input int ia, input logic [7:0] idat,
                        output int done_cyc, output int done_cnt, output int busy_cnt);
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    bus.xf_op    = op;
    bus.xf_src   = 3'(s);
    bus.xf_dst   = 3'(d);
    bus.xf_start = 1'b1;
    tick();
    if (!hold) bus.xf_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.xf_busy) busy_cnt++;
      if (bus.xf_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      bus.wr_en = 1'b0;
      rst_n     = 1'b1;
      if (c == 2) bus.xf_start = 1'b0;
      if (c == ic && kind == 1) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(ia);
        bus.wr_data = idat;
      end
      if (c == ic && kind == 2) rst_n = 1'b0;
      tick();
    end
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
  endtask

  int dc, dn, bc;

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    bus.xf_start = 1'b0; bus.xf_op = '0; bus.xf_src = '0; bus.xf_dst = '0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    tick(); tick();
    rst_n = 1'b1;

    // Reset clears a written register and the engine flags
    wr(3, 8'hA5);
    bus.rd_addr = 3'd3; #1;
    check("pre_reset_R3", {56'd0, bus.rd_data}, 64'hA5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    check("reset_busy", {63'd0, bus.xf_busy}, 64'd0);
    check("reset_done", {63'd0, bus.xf_done}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i); #1;
      check($sformatf("reset_rd%0d", i), {56'd0, bus.rd_data}, 64'd0);
    end

    // External write visible only after the edge
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = 8'(8'h11 * i);
      #1;
      check($sformatf("no_wthru%0d", i), {56'd0, bus.rd_data}, {56'd0, m[i]});
      tick();
      bus.wr_en = 1'b0;
      m[i] = 8'(8'h11 * i);
      #1;
      check($sformatf("wr_rd%0d", i), {56'd0, bus.rd_data}, {56'd0, m[i]});
    end
    check("regs_flat", bus.regs_flat, 64'h0011223344556677);

    // Copy 2->5
    wr(2, 8'h7F);
    m[5] = m[2];
    push_model("copy25");
    run_op(OP_COPY, 2, 5, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    check("copy_lat", 64'(dc), 64'd3);
    check("copy_busy", 64'(bc), 64'd3);
    drain();

    // Increment in place
    m[5] = m[5] + 8'd1;
    push_model("inc55");
    run_op(OP_INC, 5, 5, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    check("inc_lat", 64'(dc), 64'd3);
    drain();

    // Increment wraps
    wr(6, 8'hFF);
    m[1] = 8'h00;
    push_model("inc61");
    run_op(OP_INC, 6, 1, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    drain();

    // Swap 1,4
    wr(1, 8'h3C);
    wr(4, 8'hC3);
    m[1] = 8'hC3; m[4] = 8'h3C;
    push_model("swap14");
    run_op(OP_SWAP, 1, 4, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    check("swap_lat", 64'(dc), 64'd4);
    check("swap_busy", 64'(bc), 64'd4);
    check("swap_ndone", 64'(dn), 64'd1);
    drain();

    // Swap with itself leaves the bank unchanged
    push_model("swap44");
    run_op(OP_SWAP, 4, 4, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    check("swap44_lat", 64'(dc), 64'd4);
    drain();

    // Clear 3->2
    m[2] = 8'h00;
    push_model("clr32");
    run_op(OP_CLR, 3, 2, 1'b0, 0, 0, 0, 8'h00, dc, dn, bc);
    check("clr_lat", 64'(dc), 64'd3);
    drain();

    // Collision in WR1: engine write to R7 wins
    wr(0, 8'h9A);
    m[7] = 8'h9A;
    push_model("coll_r7");
    run_op(OP_COPY, 0, 7, 1'b0, 2, 1, 7, 8'h55, dc, dn, bc);
    drain();

    // Same-cycle external write elsewhere proceeds
    m[6] = 8'h66;
    push_model("coll_r6");
    run_op(OP_COPY, 0, 7, 1'b0, 2, 1, 6, 8'h66, dc, dn, bc);
    drain();

    // Source overwritten after capture does not change the result
    m[3] = 8'h9A; m[0] = 8'h01;
    push_model("tlatch");
    run_op(OP_COPY, 0, 3, 1'b0, 1, 1, 0, 8'h01, dc, dn, bc);
    drain();

    // Start held while busy is ignored
    m[2] = m[3];
    push_model("hold");
    run_op(OP_COPY, 3, 2, 1'b1, 0, 0, 0, 8'h00, dc, dn, bc);
    check("hold_ndone", 64'(dn), 64'd1);
    drain();

    // Reset during WR2 of a swap abandons it without a done pulse
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    push_model("rst_mid");
    run_op(OP_SWAP, 1, 4, 1'b0, 3, 2, 0, 8'h00, dc, dn, bc);
    check("rst_mid_ndone", 64'(dn), 64'd0);
    check("rst_mid_busy", 64'(bc), 64'd3);
    check("rst_mid_idle", {63'd0, bus.xf_busy}, 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
